// File: rtl/xdbus_arb_pkg.sv
// Shared definitions for the two-master data bus arbiter.
package xdbus_arb_pkg;
  localparam int XDB_ADDR_W   = 10;
  localparam int XDB_DATA_W   = 32;
  localparam int XDB_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;
endpackage

// File: rtl/xdbus_arb_if.sv
// Bus bundle between the two masters, the arbiter and the slave decoder.
interface xdbus_arb_if
  import xdbus_arb_pkg::*;
#(
  parameter int ADDR_W = XDB_ADDR_W,
  parameter int DATA_W = XDB_DATA_W
) ();
  logic              m0_req, m0_we, m0_lock, m0_gnt;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_gnt;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              s_sel, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;

  // Arbiter side: takes master requests, drives grants and slave strobes.
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    output s_sel, s_we, s_addr, s_wdata,
    input  s_rdata
  );

  // Environment side: masters plus the slave decoder.
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    input  s_sel, s_we, s_addr, s_wdata,
    output s_rdata
  );
endinterface

// File: rtl/xdbus_arb.sv
// Two-master data bus arbiter: fixed M0 priority, bounded M1 starvation,
// and a per-master lock that holds the bus across back-to-back accesses.
module xdbus_arb
  import xdbus_arb_pkg::*;
#(
  parameter int ADDR_W   = XDB_ADDR_W,
  parameter int DATA_W   = XDB_DATA_W,
  parameter int MAX_WAIT = XDB_MAX_WAIT
) (
  input  logic         clk,
  input  logic         rst,
  xdbus_arb_if.slave   bus,
  output logic         starved
);
  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  owner_e            owner_q;
  logic [7:0]        wait_q, wait_d;
  logic              starved_q;
  logic              g0, g1;
  logic              we_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      case (owner_q)
        OWN_M0:  g0 = bus.m0_req;
        OWN_M1:  g1 = bus.m1_req;
        default: begin
          // Starvation override beats M0's fixed priority when nobody owns the bus.
          if (starved_q && bus.m1_req) g1 = 1'b1;
          else if (bus.m0_req)         g0 = 1'b1;
          else if (bus.m1_req)         g1 = 1'b1;
        end
      endcase
    end

    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (g0) begin
      we_mux    = bus.m0_we;
      addr_mux  = bus.m0_addr;
      wdata_mux = bus.m0_wdata;
    end else if (g1) begin
      we_mux    = bus.m1_we;
      addr_mux  = bus.m1_addr;
      wdata_mux = bus.m1_wdata;
    end

    wait_d = '0;
    if (bus.m1_req && !g1)
      wait_d = (wait_q >= MAX_W8) ? MAX_W8 : wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      wait_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      if (g0)                      owner_q <= bus.m0_lock ? OWN_M0 : OWN_NONE;
      else if (g1)                 owner_q <= bus.m1_lock ? OWN_M1 : OWN_NONE;
      else if (owner_q != OWN_NONE) owner_q <= OWN_NONE;  // idle release
      wait_q    <= wait_d;
      // Flag tracks the counter value being loaded, so it is valid the same cycle as wait_q.
      starved_q <= (wait_d == MAX_W8);
    end
  end

  assign bus.m0_gnt   = g0;
  assign bus.m1_gnt   = g1;
  assign bus.s_sel    = g0 | g1;
  assign bus.s_we     = we_mux;
  assign bus.s_addr   = addr_mux;
  assign bus.s_wdata  = wdata_mux;
  assign bus.m0_rdata = bus.s_rdata;
  assign bus.m1_rdata = bus.s_rdata;
  assign starved      = starved_q;
endmodule

// File: tb/tb_xdbus_arb.sv
// Table-driven bench for xdbus_arb with a one-register slave for read-back.
module tb_xdbus_arb;
  import xdbus_arb_pkg::*;
  localparam int AW = XDB_ADDR_W;
  localparam int DW = XDB_DATA_W;

  logic clk = 1'b0;
  logic rst;
  logic starved;
  always #5 clk = ~clk;

  xdbus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  xdbus_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .starved(starved)
  );

  typedef struct {
    logic          rst, r0, l0, w0, r1, l1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, rd, erd;
    logic          um;
    logic          eg0, eg1, est;
  } vec_t;

  typedef struct {
    logic          g0, g1, sel, we, st;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Tiny slave: remembers the last written address/data pair.
  logic          use_mem = 1'b0;
  logic [DW-1:0] rd_drv = '0;
  logic [AW-1:0] slv_addr_q = '1;
  logic [DW-1:0] slv_data_q = '0;
  assign bus.s_rdata = use_mem ? ((bus.s_addr == slv_addr_q) ? slv_data_q : '0) : rd_drv;
  always @(posedge clk)
    if (bus.s_sel && bus.s_we) begin
      slv_addr_q <= bus.s_addr;
      slv_data_q <= bus.s_wdata;
    end

  function automatic vec_t mk(int i, bit rs, bit r0, bit l0, bit w0, bit r1, bit l1, bit w1,
                              bit eg0, bit eg1, bit est);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.l0 = l0; v.w0 = w0; v.r1 = r1; v.l1 = l1; v.w1 = w1;
    v.a0  = AW'(32'h100 + i);
    v.a1  = AW'(32'h200 + i);
    v.d0  = 32'hA000_0000 + DW'(i);
    v.d1  = 32'hB000_0000 + DW'(i);
    v.rd  = 32'hC000_0000 + DW'(i);
    v.erd = v.rd;
    v.um  = 1'b0;
    v.eg0 = eg0; v.eg1 = eg1; v.est = est;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e, got;
    rst = v.rst;
    bus.m0_req = v.r0; bus.m0_lock = v.l0; bus.m0_we = v.w0;
    bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req = v.r1; bus.m1_lock = v.l1; bus.m1_we = v.w1;
    bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
    use_mem = v.um; rd_drv = v.rd;
    e.g0 = v.eg0; e.g1 = v.eg1; e.sel = v.eg0 | v.eg1; e.st = v.est;
    e.we = v.eg0 ? v.w0 : (v.eg1 ? v.w1 : 1'b0);
    e.addr = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : '0);
    e.wd = v.eg0 ? v.d0 : (v.eg1 ? v.d1 : '0);
    e.rd = v.erd;
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    chk("m0_gnt",   idx, 64'(bus.m0_gnt),   64'(got.g0));
    chk("m1_gnt",   idx, 64'(bus.m1_gnt),   64'(got.g1));
    chk("s_sel",    idx, 64'(bus.s_sel),    64'(got.sel));
    chk("s_we",     idx, 64'(bus.s_we),     64'(got.we));
    chk("s_addr",   idx, 64'(bus.s_addr),   64'(got.addr));
    chk("s_wdata",  idx, 64'(bus.s_wdata),  64'(got.wd));
    chk("starved",  idx, 64'(starved),      64'(got.st));
    chk("m0_rdata", idx, 64'(bus.m0_rdata), 64'(got.rd));
    chk("m1_rdata", idx, 64'(bus.m1_rdata), 64'(got.rd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    //                 rst r0 l0 w0 r1 l1 w1  g0 g1 st
    // reset held with both requesting
    for (int i = 0; i < 3; i++) tbl.push_back(mk(i, 1, 1,0,0, 1,0,0, 0,0,0));
    // contention: 4 x M0 then forced M1, twice
    for (int i = 3; i < 7; i++) tbl.push_back(mk(i, 0, 1,0,0, 1,0,0, 1,0,0));
    tbl.push_back(mk(7,  0, 1,0,0, 1,0,0, 0,1,1));
    for (int i = 8; i < 12; i++) tbl.push_back(mk(i, 0, 1,0,0, 1,0,0, 1,0,0));
    tbl.push_back(mk(12, 0, 1,0,0, 1,0,0, 0,1,1));
    // M1 lock holds off M0; M0 gets the cycle after the unlocked access
    tbl.push_back(mk(13, 0, 0,0,0, 1,1,1, 0,1,0));
    tbl.push_back(mk(14, 0, 1,0,0, 1,1,0, 0,1,0));
    tbl.push_back(mk(15, 0, 1,0,0, 1,1,0, 0,1,0));
    tbl.push_back(mk(16, 0, 1,0,0, 1,0,0, 0,1,0));
    tbl.push_back(mk(17, 0, 1,0,0, 0,0,0, 1,0,0));
    // M0 lock then idle release
    tbl.push_back(mk(18, 0, 1,1,1, 1,0,0, 1,0,0));
    tbl.push_back(mk(19, 0, 0,0,0, 1,0,0, 0,0,0));
    tbl.push_back(mk(20, 0, 0,0,0, 1,0,1, 0,1,0));
    // M0 lock outlasts MAX_WAIT: counter saturates, M1 wins once lock drops
    for (int i = 21; i < 25; i++) tbl.push_back(mk(i, 0, 1,1,0, 1,0,0, 1,0,0));
    tbl.push_back(mk(25, 0, 1,1,0, 1,0,0, 1,0,1));
    tbl.push_back(mk(26, 0, 1,0,0, 1,0,0, 1,0,1));
    tbl.push_back(mk(27, 0, 1,0,1, 1,0,0, 0,1,1));
    tbl.push_back(mk(28, 0, 0,0,0, 0,0,0, 0,0,0));
    // reset while M0 owns the bus
    tbl.push_back(mk(29, 0, 1,1,0, 0,0,0, 1,0,0));
    tbl.push_back(mk(30, 1, 1,0,0, 1,0,0, 0,0,0));
    tbl.push_back(mk(31, 0, 0,0,0, 1,0,0, 0,1,0));
    tbl.push_back(mk(32, 0, 0,0,0, 0,0,0, 0,0,0));

    foreach (tbl[i]) apply(tbl[i], i);

    // M1 write 0x5A to 0x10, then read it back through the slave
    v = mk(33, 0, 0,0,0, 1,0,1, 0,1,0);
    v.a1 = AW'(32'h10); v.d1 = 32'h5A; v.um = 1'b1; v.erd = '0;
    apply(v, 33);
    v = mk(34, 0, 0,0,0, 1,0,0, 0,1,0);
    v.a1 = AW'(32'h10); v.um = 1'b1; v.erd = 32'h5A;
    apply(v, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
